// File: rtl/mcu_bus_master_pkg.sv
// Shared MCU bus master definitions: state encodings,
// PET bus widths, SRAM strobe polarity and a width helper.
package mcu_bus_master_pkg;

  localparam int PET_ADDR_WIDTH = 17;
  localparam int PET_DATA_WIDTH = 8;

  localparam logic STB_ACTIVE = 1'b0;
  localparam logic STB_IDLE   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SLOT,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD
  } bus_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mcu_bus_master_timer.sv
// bus_phase_timer: loadable down-counter, tc_o high at zero.
// Ports: clk, reset_n, load_i, load_val_i -> tc_o.
module bus_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/mcu_bus_master.sv
// MCU bus master: latches a strobed command, waits for a slot,
// runs one timed SRAM access; SRAM pins, busy/rd/complete/overrun out.
module mcu_bus_master
  import mcu_bus_master_pkg::*;
#(
  parameter int ADDR_WIDTH    = PET_ADDR_WIDTH,
  parameter int DATA_WIDTH    = PET_DATA_WIDTH,
  parameter int SETUP_CYCLES  = 1,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  strobe,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_we,
  input  logic                  slot_grant,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic                  clr_overrun,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  ram_data_oe,
  output logic                  ram_oe_n,
  output logic                  ram_we_n,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  complete,
  output logic                  overrun
);

  localparam int CW =
    $clog2(max2(SETUP_CYCLES, ACCESS_CYCLES)) + 1;
  localparam logic [CW-1:0] SETUP_LD =
    CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] ACCESS_LD =
    CW'(ACCESS_CYCLES - 1);

  bus_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] cap_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] ram_data_out_q;
  logic                  ram_data_oe_q;
  logic                  ram_oe_n_q;
  logic                  ram_we_n_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  complete_q;
  logic                  overrun_q;

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_tc;

  // Timer is loaded on entry to SETUP and ACCESS.
  assign tmr_load =
    (state_q == ST_WAIT_SLOT && slot_grant) ||
    (state_q == ST_SETUP && tmr_tc);
  assign tmr_val =
    (state_q == ST_WAIT_SLOT) ? SETUP_LD : ACCESS_LD;

  bus_phase_timer #(
    .W(CW)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .tc_o      (tmr_tc)
  );

  // Outputs are registered together with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      we_q           <= 1'b0;
      cap_q          <= '0;
      ram_addr_q     <= '0;
      ram_data_out_q <= '0;
      ram_data_oe_q  <= 1'b0;
      ram_oe_n_q     <= STB_IDLE;
      ram_we_n_q     <= STB_IDLE;
      busy_q         <= 1'b0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      complete_q     <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      complete_q <= 1'b0;
      if (strobe && state_q != ST_IDLE) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (strobe) begin
            addr_q  <= cmd_addr;
            data_q  <= cmd_data;
            we_q    <= cmd_we;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT_SLOT;
          end
        end
        ST_WAIT_SLOT: begin
          if (slot_grant) begin
            ram_addr_q <= addr_q;
            if (we_q) begin
              ram_data_out_q <= data_q;
              ram_data_oe_q  <= 1'b1;
            end
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_tc) begin
            ram_oe_n_q <= we_q ? STB_IDLE : STB_ACTIVE;
            ram_we_n_q <= we_q ? STB_ACTIVE : STB_IDLE;
            state_q    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (tmr_tc) begin
            ram_oe_n_q <= STB_IDLE;
            ram_we_n_q <= STB_IDLE;
            if (!we_q) begin
              cap_q <= ram_data_in;
            end
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          ram_data_oe_q <= 1'b0;
          busy_q        <= 1'b0;
          complete_q    <= 1'b1;
          if (!we_q) begin
            rd_data_q  <= cap_q;
            rd_valid_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_addr     = ram_addr_q;
  assign ram_data_out = ram_data_out_q;
  assign ram_data_oe  = ram_data_oe_q;
  assign ram_oe_n     = ram_oe_n_q;
  assign ram_we_n     = ram_we_n_q;
  assign busy         = busy_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign complete     = complete_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_mcu_bus_master.sv
// Scoreboard bench for mcu_bus_master: default timing
// instance plus a SETUP=3/ACCESS=1 instance on shared inputs.
module tb_mcu_bus_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        strobe;
  logic [16:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        cmd_we;
  logic        slot_grant;
  logic [7:0]  ram_data_in;
  logic        clr_overrun;

  logic [16:0] ram_addr, b_addr;
  logic [7:0]  ram_data_out, b_dout;
  logic        ram_data_oe, b_doe;
  logic        ram_oe_n, b_oe_n;
  logic        ram_we_n, b_we_n;
  logic        busy, b_busy;
  logic [7:0]  rd_data, b_rd_data;
  logic        rd_valid, b_rd_valid;
  logic        complete, b_complete;
  logic        overrun, b_overrun;

  always #5 clk = ~clk;

  mcu_bus_master dut (
    .clk(clk), .reset_n(reset_n), .strobe(strobe),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_we(cmd_we), .slot_grant(slot_grant),
    .ram_data_in(ram_data_in), .clr_overrun(clr_overrun),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out),
    .ram_data_oe(ram_data_oe), .ram_oe_n(ram_oe_n),
    .ram_we_n(ram_we_n), .busy(busy), .rd_data(rd_data),
    .rd_valid(rd_valid), .complete(complete),
    .overrun(overrun)
  );

  mcu_bus_master #(
    .SETUP_CYCLES(3), .ACCESS_CYCLES(1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .strobe(strobe),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_we(cmd_we), .slot_grant(slot_grant),
    .ram_data_in(ram_data_in), .clr_overrun(clr_overrun),
    .ram_addr(b_addr), .ram_data_out(b_dout),
    .ram_data_oe(b_doe), .ram_oe_n(b_oe_n),
    .ram_we_n(b_we_n), .busy(b_busy), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .complete(b_complete),
    .overrun(b_overrun)
  );

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int c0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       we;
    logic [7:0] d;
    int         at;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    strobe      = 1'b0;
    clr_overrun = 1'b0;
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    exp_t e;
    if (complete) begin
      if (q1.size() == 0) begin
        chk("a_unexpected_complete", 32'(complete), 32'd0);
      end else begin
        e = q1.pop_front();
        chk("a_complete_cycle", 32'(cyc), 32'(e.at));
        chk("a_rd_valid", 32'(rd_valid), 32'(!e.we));
        if (!e.we) chk("a_rd_data", 32'(rd_data), 32'(e.d));
      end
    end else if (rd_valid) begin
      chk("a_rd_valid_alone", 32'(rd_valid), 32'd0);
    end
    if (b_complete && q2.size() > 0) begin
      e = q2.pop_front();
      chk("b_complete_cycle", 32'(cyc), 32'(e.at));
      chk("b_rd_data", 32'(b_rd_data), 32'(e.d));
    end
  end

  always @(negedge clk) begin
    if (!ram_oe_n && !ram_we_n) begin
      failures++;
      $display("FAIL a_oe_we_both_low cyc=%0d", cyc);
    end
    if (!b_oe_n && !b_we_n) begin
      failures++;
      $display("FAIL b_oe_we_both_low cyc=%0d", cyc);
    end
  end

  initial begin
    reset_n = 1'b0;
    idle_in();
    cmd_we = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
    slot_grant = 1'b1;
    ram_data_in = 8'hA5;
    repeat (3) nxt();
    @(negedge clk);
    chk("rst_oe_n", 32'(ram_oe_n), 32'd1);
    chk("rst_we_n", 32'(ram_we_n), 32'd1);
    chk("rst_doe", 32'(ram_data_oe), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_dout", 32'(ram_data_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_flags",
        32'({rd_valid, complete, overrun}), 32'd0);
    nxt();
    reset_n = 1'b1;
    nxt();

    // 1: read with grant already high
    c0 = cyc;
    for (int k = 0; k <= 8; k++) begin
      idle_in();
      strobe = (k == 0);
      cmd_we = 1'b0;
      cmd_addr = 17'h08000;
      if (k == 0) begin
        q1.push_back('{1'b0, 8'hA5, c0 + 6});
        q2.push_back('{1'b0, 8'hA5, c0 + 7});
      end
      @(negedge clk);
      if (k >= 1 && k <= 7) begin
        chk("t1_oe_n", 32'(ram_oe_n),
            (k == 3 || k == 4) ? 32'd0 : 32'd1);
        chk("t1_we_n", 32'(ram_we_n), 32'd1);
        chk("t1_doe", 32'(ram_data_oe), 32'd0);
      end
      if (k == 2) chk("t1_addr", 32'(ram_addr), 32'h08000);
      if (k == 1) chk("t1_busy", 32'(busy), 32'd1);
      if (k == 6) chk("t1_busy_end", 32'(busy), 32'd0);
      nxt();
    end

    // 2: write waiting 10 cycles for the slot
    slot_grant = 1'b0;
    c0 = cyc;
    for (int k = 0; k <= 17; k++) begin
      idle_in();
      strobe = (k == 0);
      cmd_we = 1'b1;
      cmd_addr = 17'h1FFFF;
      cmd_data = 8'h3C;
      if (k == 11) begin
        slot_grant = 1'b1;
        q1.push_back('{1'b1, 8'h00, c0 + 16});
      end
      @(negedge clk);
      if (k >= 1 && k <= 10) begin
        chk("t2_wait_busy", 32'(busy), 32'd1);
        chk("t2_wait_quiet",
            32'({ram_oe_n, ram_we_n, ram_data_oe}), 32'b110);
      end
      if (k >= 12 && k <= 16) begin
        chk("t2_doe", 32'(ram_data_oe),
            (k <= 15) ? 32'd1 : 32'd0);
        chk("t2_we_n", 32'(ram_we_n),
            (k == 13 || k == 14) ? 32'd0 : 32'd1);
        chk("t2_oe_n", 32'(ram_oe_n), 32'd1);
      end
      if (k >= 12 && k <= 15) begin
        chk("t2_dout", 32'(ram_data_out), 32'h3C);
        chk("t2_addr", 32'(ram_addr), 32'h1FFFF);
      end
      nxt();
    end
    repeat (6) nxt();

    // 3: overrun during ACCESS, then clear
    ram_data_in = 8'h5A;
    c0 = cyc;
    for (int k = 0; k <= 12; k++) begin
      idle_in();
      strobe = (k == 0 || k == 3);
      cmd_we = (k == 3);
      cmd_addr = (k == 3) ? 17'h00456 : 17'h00123;
      cmd_data = 8'hFF;
      clr_overrun = (k == 11);
      if (k == 0) q1.push_back('{1'b0, 8'h5A, c0 + 6});
      @(negedge clk);
      if (k >= 4 && k <= 11)
        chk("t3_overrun", 32'(overrun), 32'd1);
      if (k == 12)
        chk("t3_clr", 32'(overrun), 32'd0);
      chk("t3_no_write", 32'(ram_we_n), 32'd1);
      if (k >= 2 && k <= 5)
        chk("t3_addr", 32'(ram_addr), 32'h00123);
      nxt();
    end

    // 3b: set and clear together, set wins
    c0 = cyc;
    for (int k = 0; k <= 10; k++) begin
      idle_in();
      strobe = (k == 0 || k == 2);
      cmd_we = 1'b0;
      cmd_addr = 17'h00124;
      clr_overrun = (k == 2 || k == 9);
      if (k == 0) q1.push_back('{1'b0, 8'h5A, c0 + 6});
      @(negedge clk);
      if (k == 3)
        chk("t3b_set_wins", 32'(overrun), 32'd1);
      if (k == 10)
        chk("t3b_clr", 32'(overrun), 32'd0);
      nxt();
    end
    repeat (4) nxt();

    // 4: back-to-back, strobe in the complete cycle
    ram_data_in = 8'h11;
    c0 = cyc;
    for (int k = 0; k <= 14; k++) begin
      idle_in();
      strobe = (k == 0 || k == 6);
      cmd_we = (k == 6);
      cmd_addr = (k == 6) ? 17'h00020 : 17'h00010;
      cmd_data = 8'h77;
      if (k == 0) q1.push_back('{1'b0, 8'h11, c0 + 6});
      if (k == 6) q1.push_back('{1'b1, 8'h00, c0 + 12});
      @(negedge clk);
      if (k == 7) begin
        chk("t4_no_overrun", 32'(overrun), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
      end
      if (k == 8) begin
        chk("t4_addr2", 32'(ram_addr), 32'h00020);
        chk("t4_dout2", 32'(ram_data_out), 32'h77);
      end
      if (k >= 7 && k <= 12)
        chk("t4_we_n", 32'(ram_we_n),
            (k == 9 || k == 10) ? 32'd0 : 32'd1);
      nxt();
    end
    repeat (4) nxt();

    // 5: reset during write ACCESS
    c0 = cyc;
    for (int k = 0; k <= 10; k++) begin
      idle_in();
      strobe = (k == 0);
      cmd_we = 1'b1;
      cmd_addr = 17'h00055;
      cmd_data = 8'hAA;
      reset_n = (k != 3);
      @(negedge clk);
      if (k == 3)
        chk("t5_pre_we_n", 32'(ram_we_n), 32'd0);
      if (k == 4) begin
        chk("t5_we_n", 32'(ram_we_n), 32'd1);
        chk("t5_doe", 32'(ram_data_oe), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_rd_data", 32'(rd_data), 32'd0);
      end
      nxt();
    end

    ram_data_in = 8'h99;
    c0 = cyc;
    for (int k = 0; k <= 9; k++) begin
      idle_in();
      strobe = (k == 0);
      cmd_we = 1'b0;
      cmd_addr = 17'h00777;
      if (k == 0) begin
        q1.push_back('{1'b0, 8'h99, c0 + 6});
        q2.push_back('{1'b0, 8'h99, c0 + 7});
      end
      @(negedge clk);
      if (k == 2) chk("t5_addr", 32'(ram_addr), 32'h00777);
      nxt();
    end

    idle_in();
    for (int i = 0; i < 50 && (q1.size() + q2.size()) > 0; i++)
      nxt();
    chk("queues_drained", 32'(q1.size() + q2.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
